// File: rtl/uart_tx_sched_if.sv
// Requester/transmitter bundle shared between the UART scheduler and its environment.
// Latency: none (wires only).
// Backpressure: requesters hold req_valid/req_data until req_ready; tx_busy stalls launches.
interface uart_tx_sched_if #(
   parameter int N_REQ = 4
);
   logic [N_REQ-1:0]   req_valid;
   logic [8*N_REQ-1:0] req_data;
   logic [N_REQ-1:0]   req_psel;
   logic [N_REQ-1:0]   req_ready;
   logic [N_REQ-1:0]   grant;
   logic               tx_start;
   logic [7:0]         tx_data;
   logic               tx_psel;
   logic               tx_busy;
   logic               tx_done;
   logic               err_timeout;

   // Scheduler side
   modport master (
      input  req_valid, req_data, req_psel, tx_busy, tx_done,
      output req_ready, grant, tx_start, tx_data, tx_psel, err_timeout
   );

   // Requesters plus transmitter side
   modport slave (
      output req_valid, req_data, req_psel, tx_busy, tx_done,
      input  req_ready, grant, tx_start, tx_data, tx_psel, err_timeout
   );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte producers, bursts up to BURST.
// Latency: grant 1 cycle after req_valid in IDLE, tx_start/req_ready 1 cycle after that.
// Backpressure: stalls in SEND while tx_busy; a watchdog releases the grant if tx_done never comes.
module uart_tx_sched #(
   parameter int N_REQ   = 4,
   parameter int BURST   = 4,
   parameter int TIMEOUT = 50000
) (
   input  logic            clk,
   input  logic            rst,
   uart_tx_sched_if.master bus
);
   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      SEND      = 2'd1,
      WAIT_DONE = 2'd2
   } state_t;

   state_t           state;
   logic [IDX_W-1:0] rr_ptr;
   logic [IDX_W-1:0] owner;
   logic [3:0]       burst_cnt;
   logic [15:0]      wd_cnt;

   logic [N_REQ-1:0] req_ready;
   logic [N_REQ-1:0] grant;
   logic             tx_start;
   logic [7:0]       tx_data;
   logic             tx_psel;
   logic             err_timeout;

   logic             win_found;
   logic [IDX_W-1:0] win_idx;
   logic [IDX_W-1:0] next_ptr;
   logic             owner_valid;
   logic [7:0]       owner_data;

   assign bus.req_ready   = req_ready;
   assign bus.grant       = grant;
   assign bus.tx_start    = tx_start;
   assign bus.tx_data     = tx_data;
   assign bus.tx_psel     = tx_psel;
   assign bus.err_timeout = err_timeout;

   assign owner_valid = bus.req_valid[owner];
   assign owner_data  = bus.req_data[{owner, 3'b000} +: 8];
   assign next_ptr    = (owner == IDX_W'(N_REQ - 1)) ? '0 : owner + IDX_W'(1);

   // Pick the first valid requester at or after rr_ptr, wrapping modulo N_REQ
   always_comb begin
      int               j;
      logic [IDX_W-1:0] jj;
      win_found = 1'b0;
      win_idx   = '0;
      j         = 0;
      jj        = '0;
      // Scan from the far end so the closest candidate to rr_ptr is the last one written
      for (int k = N_REQ - 1; k >= 0; k--) begin
         j = int'(rr_ptr) + k;
         if (j >= N_REQ) begin
            j = j - N_REQ;
         end
         jj = IDX_W'(j);
         if (bus.req_valid[jj]) begin
            win_found = 1'b1;
            win_idx   = jj;
         end
      end
   end

   // Scheduler FSM: grant, launch one frame per byte, wait for done or watchdog, release
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         rr_ptr      <= '0;
         owner       <= '0;
         burst_cnt   <= '0;
         wd_cnt      <= '0;
         req_ready   <= '0;
         grant       <= '0;
         tx_start    <= 1'b0;
         tx_data     <= '0;
         tx_psel     <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         tx_start    <= 1'b0;
         req_ready   <= '0;
         err_timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (win_found) begin
                  grant   <= N_REQ'(1) << win_idx;
                  owner   <= win_idx;
                  tx_psel <= bus.req_psel[win_idx];
                  state   <= SEND;
               end
            end
            SEND: begin
               if (!owner_valid) begin
                  grant     <= '0;
                  burst_cnt <= '0;
                  rr_ptr    <= next_ptr;
                  state     <= IDLE;
               end else if (!bus.tx_busy) begin
                  tx_data          <= owner_data;
                  tx_start         <= 1'b1;
                  req_ready[owner] <= 1'b1;
                  burst_cnt        <= burst_cnt + 4'd1;
                  wd_cnt           <= '0;
                  state            <= WAIT_DONE;
               end
            end
            WAIT_DONE: begin
               if (bus.tx_done) begin
                  if (burst_cnt < 4'(BURST)) begin
                     state <= SEND;
                  end else begin
                     grant     <= '0;
                     burst_cnt <= '0;
                     rr_ptr    <= next_ptr;
                     state     <= IDLE;
                  end
               end else if (wd_cnt == 16'(TIMEOUT - 1)) begin
                  // Frame never finished: flag it and hand the line to the next requester
                  err_timeout <= 1'b1;
                  grant       <= '0;
                  burst_cnt   <= '0;
                  rr_ptr      <= next_ptr;
                  state       <= IDLE;
               end else begin
                  wd_cnt <= wd_cnt + 16'd1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: directed requester/transmitter traffic with a scoreboard on tx_start/err_timeout.
// Latency: expected events carry the hand-computed cycle in which they must appear.
// Backpressure: requester model drops a byte when req_ready is seen; tx_busy driven per test.
module tb_uart_tx_sched;
   logic        clk;
   logic        rst;
   logic        sel;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_psel;
   logic        tx_busy;
   logic        tx_done;

   logic [3:0]  m_ready;
   logic [3:0]  m_grant;
   logic        m_start;
   logic [7:0]  m_data;
   logic        m_psel;
   logic        m_err;

   typedef struct {
      bit         tmo;
      logic [7:0] data;
      logic       psel;
      logic [3:0] grant;
      int         cyc;
   } exp_t;

   exp_t       expq[$];
   logic [7:0] rq[4][$];
   int         cyc;
   int         frame_len;
   int         tx_left;
   int         total;
   int         bad;
   int         mon_total;
   int         mon_bad;
   int         stall_seen;
   logic       prev_start;

   uart_tx_sched_if #(.N_REQ(4)) ifa ();
   uart_tx_sched_if #(.N_REQ(4)) ifb ();

   // dut_a: BURST=4, dut_b: BURST=1; both share stimulus, the monitor watches the selected one
   uart_tx_sched #(.N_REQ(4), .BURST(4), .TIMEOUT(100)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
   uart_tx_sched #(.N_REQ(4), .BURST(1), .TIMEOUT(100)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

   assign ifa.req_valid = req_valid;
   assign ifa.req_data  = req_data;
   assign ifa.req_psel  = req_psel;
   assign ifa.tx_busy   = tx_busy;
   assign ifa.tx_done   = tx_done;
   assign ifb.req_valid = req_valid;
   assign ifb.req_data  = req_data;
   assign ifb.req_psel  = req_psel;
   assign ifb.tx_busy   = tx_busy;
   assign ifb.tx_done   = tx_done;

   assign m_ready = sel ? ifb.req_ready   : ifa.req_ready;
   assign m_grant = sel ? ifb.grant       : ifa.grant;
   assign m_start = sel ? ifb.tx_start    : ifa.tx_start;
   assign m_data  = sel ? ifb.tx_data     : ifa.tx_data;
   assign m_psel  = sel ? ifb.tx_psel     : ifa.tx_psel;
   assign m_err   = sel ? ifb.err_timeout : ifa.err_timeout;

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h (cyc %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic mchk(string nm, logic [31:0] act, logic [31:0] exp);
      mon_total++;
      if (act !== exp) begin
         mon_bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h (cyc %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic push_start(int c, logic [7:0] d, logic p, logic [3:0] g);
      exp_t e;
      e.tmo = 1'b0; e.data = d; e.psel = p; e.grant = g; e.cyc = c;
      expq.push_back(e);
   endtask

   task automatic push_tmo(int c);
      exp_t e;
      e.tmo = 1'b1; e.data = 8'h00; e.psel = 1'b0; e.grant = 4'b0000; e.cyc = c;
      expq.push_back(e);
   endtask

   task automatic drive_reqs();
      for (int i = 0; i < 4; i++) begin
         req_valid[i]       = (rq[i].size() > 0);
         req_data[8*i +: 8] = (rq[i].size() > 0) ? rq[i][0] : 8'h00;
      end
   endtask

   // One clock: requester pops on req_ready, transmitter model counts down to tx_done
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < 4; i++) begin
         if (m_ready[i] && rq[i].size() > 0) void'(rq[i].pop_front());
      end
      tx_done = 1'b0;
      if (rst) begin
         tx_left = 0;
      end else if (m_start) begin
         tx_left = frame_len;
      end else if (tx_left > 0) begin
         tx_left--;
         if (tx_left == 0) tx_done = 1'b1;
      end
      drive_reqs();
   endtask

   task automatic run_to(int c);
      while (cyc < c) step();
   endtask

   task automatic do_reset(logic s);
      sel       = s;
      rst       = 1'b1;
      frame_len = 0;
      tx_busy   = 1'b0;
      req_psel  = 4'b0000;
      for (int i = 0; i < 4; i++) rq[i].delete();
      drive_reqs();
      step();
      step();
      rst = 1'b0;
      cyc = 0;
   endtask

   task automatic chk_all_zero(string tag);
      chk({tag, "_grant"}, m_grant, 0);
      chk({tag, "_req_ready"}, m_ready, 0);
      chk({tag, "_tx_start"}, m_start, 0);
      chk({tag, "_tx_data"}, m_data, 0);
      chk({tag, "_tx_psel"}, m_psel, 0);
      chk({tag, "_err_timeout"}, m_err, 0);
   endtask

   // Monitor: pops the scoreboard whenever the selected DUT emits tx_start or err_timeout
   initial begin
      exp_t e;
      prev_start = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_start = 1'b0;
         end else begin
            if (m_start || m_err) begin
               if (expq.size() == 0) begin
                  mon_total++;
                  mon_bad++;
                  $display("FAIL unexpected_output: tx_start=%0b err_timeout=%0b with nothing expected (cyc %0d)",
                           m_start, m_err, cyc);
               end else begin
                  e = expq.pop_front();
                  mchk("event_kind", {30'd0, m_err, m_start}, e.tmo ? 32'd2 : 32'd1);
                  mchk("event_cycle", cyc, e.cyc);
                  mchk("event_grant", m_grant, e.grant);
                  if (!e.tmo) begin
                     mchk("tx_data", m_data, e.data);
                     mchk("tx_psel", m_psel, e.psel);
                     mchk("req_ready", m_ready, e.grant);
                  end
               end
            end
            if (!m_start) mchk("ready_without_start", m_ready, 0);
            else mchk("start_back_to_back", prev_start, 0);
            prev_start = m_start;
         end
      end
   end

   // Directed stimulus
   initial begin
      total = 0; bad = 0; mon_total = 0; mon_bad = 0;
      cyc = 0; tx_left = 0; frame_len = 0;
      rst = 1'b1; sel = 1'b0; tx_busy = 1'b0; tx_done = 1'b0;
      req_valid = '0; req_data = '0; req_psel = '0;

      // Single requester
      do_reset(1'b0);
      chk_all_zero("reset");
      req_psel = 4'b0001;
      frame_len = 5;
      rq[0].push_back(8'hA5);
      drive_reqs();
      push_start(2, 8'hA5, 1'b1, 4'b0001);
      step();
      chk("t1_grant_c1", m_grant, 4'b0001);
      run_to(8);
      chk("t1_grant_held", m_grant, 4'b0001);
      run_to(9);
      chk("t1_grant_released", m_grant, 4'b0000);
      run_to(12);

      // Round robin, BURST=1
      do_reset(1'b1);
      req_psel = 4'b1010;
      frame_len = 3;
      rq[0].push_back(8'h10); rq[0].push_back(8'h11);
      rq[1].push_back(8'h20); rq[1].push_back(8'h21);
      rq[2].push_back(8'h30); rq[2].push_back(8'h31);
      rq[3].push_back(8'h40); rq[3].push_back(8'h41);
      drive_reqs();
      push_start(2,  8'h10, 1'b0, 4'b0001);
      push_start(8,  8'h20, 1'b1, 4'b0010);
      push_start(14, 8'h30, 1'b0, 4'b0100);
      push_start(20, 8'h40, 1'b1, 4'b1000);
      push_start(26, 8'h11, 1'b0, 4'b0001);
      push_start(32, 8'h21, 1'b1, 4'b0010);
      push_start(38, 8'h31, 1'b0, 4'b0100);
      push_start(44, 8'h41, 1'b1, 4'b1000);
      run_to(50);

      // Burst limit, BURST=4, with a psel toggle mid-burst
      do_reset(1'b0);
      req_psel = 4'b1000;
      frame_len = 2;
      for (int b = 0; b < 6; b++) rq[2].push_back(8'hC0 + 8'(b));
      rq[3].push_back(8'hD0);
      drive_reqs();
      push_start(2,  8'hC0, 1'b0, 4'b0100);
      push_start(6,  8'hC1, 1'b0, 4'b0100);
      push_start(10, 8'hC2, 1'b0, 4'b0100);
      push_start(14, 8'hC3, 1'b0, 4'b0100);
      push_start(19, 8'hD0, 1'b1, 4'b1000);
      push_start(25, 8'hC4, 1'b1, 4'b0100);
      push_start(29, 8'hC5, 1'b1, 4'b0100);
      run_to(7);
      req_psel[2] = 1'b1;
      run_to(18);
      chk("t3_grant_handover", m_grant, 4'b1000);
      run_to(35);

      // Busy stall for 20 cycles in SEND
      do_reset(1'b0);
      tx_busy = 1'b1;
      frame_len = 3;
      rq[1].push_back(8'h5A);
      drive_reqs();
      push_start(22, 8'h5A, 1'b0, 4'b0010);
      stall_seen = 0;
      while (cyc < 21) begin
         step();
         if (m_start || m_ready != 4'b0000) stall_seen++;
      end
      chk("t4_stall_quiet", stall_seen, 0);
      chk("t4_grant_during_stall", m_grant, 4'b0010);
      tx_busy = 1'b0;
      run_to(30);

      // Watchdog, TIMEOUT=100
      do_reset(1'b0);
      req_psel = 4'b0001;
      frame_len = 0;
      rq[0].push_back(8'h77); rq[0].push_back(8'h78);
      rq[1].push_back(8'h88);
      drive_reqs();
      push_start(2, 8'h77, 1'b1, 4'b0001);
      push_tmo(102);
      push_start(104, 8'h88, 1'b0, 4'b0010);
      push_start(111, 8'h78, 1'b1, 4'b0001);
      run_to(102);
      frame_len = 3;
      run_to(103);
      chk("t5_err_single_pulse", m_err, 1'b0);
      chk("t5_rr_advanced_grant", m_grant, 4'b0010);
      run_to(118);

      // Reset mid-burst
      do_reset(1'b0);
      req_psel = 4'b0100;
      frame_len = 3;
      rq[1].push_back(8'hB1);
      rq[2].push_back(8'hE0); rq[2].push_back(8'hE1);
      drive_reqs();
      push_start(2, 8'hB1, 1'b0, 4'b0010);
      push_start(9, 8'hE0, 1'b1, 4'b0100);
      run_to(6);
      frame_len = 0;
      run_to(12);
      chk("t6_grant_before_rst", m_grant, 4'b0100);
      rst = 1'b1;
      rq[0].push_back(8'hF0);
      drive_reqs();
      push_start(15, 8'hF0, 1'b0, 4'b0001);
      push_start(22, 8'hE1, 1'b1, 4'b0100);
      step();
      chk_all_zero("t6_after_rst");
      rst = 1'b0;
      frame_len = 3;
      run_to(29);

      chk("scoreboard_drained", expq.size(), 0);
      total = total + mon_total;
      bad   = bad + mon_bad;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Round-robin scheduler that shares one UART transmitter between `N_REQ` byte producers. Each requester offers bytes on a valid/ready handshake. The scheduler grants the transmitter to one requester for a burst of up to `BURST` frames and forwards that requester's parity selection. It then issues one start pulse per byte and waits for the transmitter's frame-done pulse. A watchdog releases the grant if a frame never completes.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `BURST`, 4: maximum frames per grant (1..15).
- `TIMEOUT`, 16'd50000: cycles allowed from `tx_start` to `tx_done` before abort.

- `clk`  in  1  system clock
- `rst`  in  1  synchronous reset, active-high
- `req_valid`  in  N_REQ  requester i has a byte pending
- `req_data`  in  8*N_REQ  byte of requester i at bits [8i+7:8i]
- `req_psel`  in  N_REQ  parity select of requester i (0 = even, 1 = odd)
- `req_ready`  out  N_REQ  one-cycle pulse: byte of requester i accepted
- `grant`  out  N_REQ  one-hot current owner, 0 when idle
- `tx_start`  out  1  one-cycle pulse: transmitter loads `tx_data`
- `tx_data`  out  8  byte to transmit, valid while `tx_start` = 1
- `tx_psel`  out  1  parity select of current owner
- `tx_busy`  in  1  transmitter is shifting a frame
- `tx_done`  in  1  one-cycle pulse at end of stop bit
- `err_timeout`  out  1  one-cycle pulse on watchdog abort

## Operation
- All outputs are registered. Reset values:
  - `req_ready`, `grant`, `tx_start`, `tx_data`, `tx_psel`, `err_timeout` = 0.
  - State = IDLE, `rr_ptr` = 0, `burst_cnt` = 0, `wd_cnt` = 0.
- States and transitions:
  - IDLE: the winner is the first i with `req_valid[i]` = 1, searching from `rr_ptr` upward modulo `N_REQ`. On the clock edge, register `grant` = onehot(winner) and `tx_psel` = `req_psel[winner]`, then go to SEND. If no requester is valid, stay in IDLE.
  - SEND, owner valid and `tx_busy` = 0:
    - Capture `req_data[owner]` into `tx_data`.
    - Next cycle: `tx_start` = 1 and `req_ready[owner]` = 1.
    - `burst_cnt` += 1, `wd_cnt` = 0, go to WAIT_DONE.
  - SEND, owner valid and `tx_busy` = 1: stall in SEND.
  - SEND, owner `req_valid` = 0: RELEASE.
  - WAIT_DONE, `tx_done` = 1: if `burst_cnt` < `BURST`, go to SEND; otherwise RELEASE.
  - WAIT_DONE, `wd_cnt` = `TIMEOUT`-1 with no `tx_done`: pulse `err_timeout`, then RELEASE.
  - WAIT_DONE otherwise: `wd_cnt` += 1.
  - RELEASE (an action taken on the transition, not a held state):
    - `grant` = 0, `burst_cnt` = 0.
    - `rr_ptr` = (owner+1) mod `N_REQ`.
    - Next state is IDLE.
- `tx_psel` is latched at grant and does not change during a burst, even if `req_psel` toggles.
- Requester rule: hold `req_valid` and `req_data` stable until `req_ready` is seen. The byte is sampled on the edge leaving SEND.
- Non-owners never see `req_ready`. At most one bit of `req_ready` is set at a time.
- `tx_done` outside WAIT_DONE is ignored.
- `rst` mid-frame returns every register to its reset value on the next edge. The transmitter's in-flight frame is not tracked, and no `req_ready` pulse is issued for it.
- Counter widths:
  - `rr_ptr` is $clog2(`N_REQ`) bits and wraps modulo `N_REQ`, including non-power-of-two values.
  - `burst_cnt` is 4 bits.
  - `wd_cnt` is 16 bits and saturates at `TIMEOUT`-1.

## Timing
- Cycle 0: `req_valid[i]` rises while in IDLE.
- Cycle 1: `grant[i]` = 1, state SEND.
- Cycle 2: `tx_start` = 1 and `req_ready[i]` = 1, if `tx_busy` = 0 in cycle 1.
- Back-to-back frames within a burst:
  - `tx_done` in cycle k → SEND in cycle k+1 → `tx_start` in cycle k+2, provided the owner is still valid and `tx_busy` = 0.
- Handover between owners:
  - Release on `tx_done` in cycle k → IDLE in cycle k+1 → new `grant` in cycle k+2 → `tx_start` in cycle k+3.
- `err_timeout` asserts in the cycle after `wd_cnt` reaches `TIMEOUT`-1. `grant` falls in the same cycle.
- `tx_start` is never high in two consecutive cycles. `tx_start` never asserts while `tx_busy` = 1 was sampled in SEND.

## Test plan
- Single requester: `rst` then `req_valid` = 0001, `req_data[7:0]` = 8'hA5, `req_psel[0]` = 1.
  - Expect `grant` = 0001 at cycle 1.
  - Expect `tx_start`, `tx_data` = A5, `tx_psel` = 1 and `req_ready` = 0001 at cycle 2.
  - After `tx_done`, with `req_valid` dropped: `grant` = 0 two cycles later.
- Round robin: all four requesters valid continuously, `BURST` = 1.
  - Grant order 0,1,2,3,0.
  - Each `req_ready` follows its `tx_start` in the same cycle.
  - No requester is served twice before the others.
- Burst limit: requester 2 always valid, `BURST` = 4, requester 3 also valid.
  - Requester 2 receives exactly 4 `tx_start` pulses, then `grant` = 1000.
- Busy stall: `tx_busy` = 1 held for 20 cycles while in SEND.
  - No `tx_start` and no `req_ready` during the stall.
  - `tx_start` asserts 1 cycle after `tx_busy` falls.
- Watchdog: `TIMEOUT` = 100, `tx_done` withheld.
  - `err_timeout` pulses exactly 100 cycles after `tx_start`.
  - `grant` = 0 and `rr_ptr` advances.
- Reset mid-burst: assert `rst` in WAIT_DONE with `grant` = 0100.
  - Next cycle: all outputs are 0.
  - First grant after reset goes to the lowest-index valid requester.
